pb_mode_ctrl: RTL
=================

# pb_mode_ctrl

Pushbutton sequencer for the segway operator button. Synchronizes the raw active-low button, debounces press and release, classifies each accepted press as short or long, and applies the result to the operator configuration: a short press steps the assist mode, a long press toggles enable. Sits between the board button pin and the balance/steer control blocks and replaces ad-hoc release-edge detection for operator commands.

## Interface
- DEBOUNCE, 50000: cycles PB must be stable (low to accept a press, high to accept a release); must be ≥ 2
- LONG_CYCLES, 50000000: cycles of continuous low PB, counted from the first synchronized low, at which a press becomes long; must be > DEBOUNCE
- NUM_MODES, 4: number of assist modes; must be ≥ 2; MW = $clog2(NUM_MODES)

- clk  in  1  system clock; the block's only clock
- rst_n  in  1  asynchronous active-low reset
- PB  in  1  raw pushbutton, asynchronous, active-low (idle high)
- lock  in  1  synchronous; when high, commands are classified but not applied
- short_press  out  1  one-cycle pulse: accepted short press completed
- long_press  out  1  one-cycle pulse: held press crossed LONG_CYCLES
- rejected  out  1  one-cycle pulse, coincident with short_press/long_press, when lock was high on that cycle
- mode  out  MW  current assist mode, 0..NUM_MODES-1
- en  out  1  operator enable
- busy  out  1  high whenever FSM is not IDLE

## Operation
- PB passes through a 3-flop synchronizer; all flops reset to 1. pbs = third flop output.
- One counter cnt, width $clog2(LONG_CYCLES+1), saturating at LONG_CYCLES; cleared on every state change unless stated.
- States: IDLE, DB_PRESS, HELD, LONG_HELD, DB_REL.
- IDLE: pbs==0 → DB_PRESS, cnt=0.
- DB_PRESS: pbs==1 → IDLE (glitch, no output). pbs==0 and cnt==DEBOUNCE-1 → HELD, cnt NOT cleared. Else cnt++.
- HELD: pbs==1 → DB_REL, short flag set. pbs==0 and cnt==LONG_CYCLES-1 → LONG_HELD, fire long command. Else cnt++.
- LONG_HELD: wait; pbs==1 → DB_REL, short flag clear.
- DB_REL: pbs==0 → cnt=0, stay (bounce restarts release debounce; no return to HELD). pbs==1 and cnt==DEBOUNCE-1 → IDLE, fire short command if short flag set. Else cnt++.
- Short command: short_press pulse. If lock==0: mode = (mode==NUM_MODES-1) ? 0 : mode+1. If lock==1: rejected pulse, mode unchanged.
- Long command: long_press pulse. If lock==0: en = ~en, mode = 0. If lock==1: rejected pulse, en/mode unchanged.
- lock sampled on the cycle of the command transition only; later changes have no retroactive effect.
- At most one command per physical press; a long press never also yields a short press.

## Timing
- Reset: synchronizer flops=1, state=IDLE, cnt=0, short flag=0, short_press=0, long_press=0, rejected=0, mode=0, en=0, busy=0.
- All outputs registered. Pulses assert the cycle after the triggering transition edge; mode/en update on that same edge.
- PB→pbs latency: 3 cycles.
- Clean press: short_press asserts (3 + held_cycles + DEBOUNCE + 1) cycles after PB falls, where held_cycles is the synchronized low duration.
- Long: long_press asserts at cycle (3 + LONG_CYCLES + 1) after PB falls while still held.
- busy = (state != IDLE), registered with state.
- Reset asserted mid-press: all state cleared immediately; no pulse issued; after release, a still-low PB is treated as a new press (3 sync cycles + DEBOUNCE).
- Mode wrap: NUM_MODES-1 → 0 on short press; no other arithmetic wraps (cnt saturates).

## Test plan
(DEBOUNCE=4, LONG_CYCLES=20, NUM_MODES=3)
- Reset, PB=1 → mode=0, en=0, busy=0, no pulses for 50 cycles.
- PB low 2 cycles (glitch) → busy pulses, returns IDLE, no short_press, mode stays 0.
- Three clean presses of 8 cycles, lock=0 → three short_press pulses; mode 1, 2, 0 (wrap).
- PB low 30 cycles, lock=0 → long_press exactly at cycle 24 after fall, en=1, mode=0; no short_press on release.
- Release bouncing high/low 3 times at 2-cycle spacing then steady → one short_press, only after 4 continuous high synchronized cycles.
- lock=1, short press then long press → short_press and long_press each with coincident rejected; mode and en unchanged; rst_n pulsed mid-hold → no pulse, outputs return to reset values.

Source files
------------

// File: rtl/pb_mode_ctrl.sv
// pb_mode_ctrl: operator pushbutton sequencer.
// Synchronizes the raw active-low button, debounces press and release,
// classifies each accepted press as short or long, and applies it to the
// assist mode (short press) or the operator enable (long press).
module pb_mode_ctrl #(
    parameter  int unsigned DEBOUNCE    = 50000,
    parameter  int unsigned LONG_CYCLES = 50000000,
    parameter  int unsigned NUM_MODES   = 4,
    localparam int unsigned MW          = $clog2(NUM_MODES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PB,
    input  logic          lock,
    output logic          short_press,
    output logic          long_press,
    output logic          rejected,
    output logic [MW-1:0] mode,
    output logic          en,
    output logic          busy
);

    localparam int unsigned CW = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(LONG_CYCLES);
    localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_HELD,
        S_LONG_HELD,
        S_DB_REL
    } state_t;

    logic [2:0]    sync_q, sync_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          short_flag_q, short_flag_d;
    logic          short_press_q, short_press_d;
    logic          long_press_q, long_press_d;
    logic          rejected_q, rejected_d;
    logic [MW-1:0] mode_q, mode_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;

    logic          pbs;
    logic [CW-1:0] cnt_inc;
    logic          fire_short;
    logic          fire_long;

    assign pbs = sync_q[2];

    // Three-stage synchronizer shift; idles high like the button itself.
    always_comb begin
        sync_d = {sync_q[1:0], PB};
    end

    // Press/release sequencing; produces one-cycle command strobes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        short_flag_d = short_flag_q;
        fire_short   = 1'b0;
        fire_long    = 1'b0;
        cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!pbs) begin
                    state_d = S_DB_PRESS;
                    cnt_d   = '0;
                end
            end
            S_DB_PRESS: begin
                if (pbs) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    // keep counting so the long threshold is measured from
                    // the first synchronized low, not from acceptance
                    state_d = S_HELD;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HELD: begin
                if (pbs) begin
                    state_d      = S_DB_REL;
                    cnt_d        = '0;
                    short_flag_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d   = S_LONG_HELD;
                    cnt_d     = '0;
                    fire_long = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LONG_HELD: begin
                if (pbs) begin
                    state_d      = S_DB_REL;
                    cnt_d        = '0;
                    short_flag_d = 1'b0;
                end
            end
            S_DB_REL: begin
                if (!pbs) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    fire_short = short_flag_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Apply commands to mode/enable unless locked; build registered outputs.
    always_comb begin
        short_press_d = fire_short;
        long_press_d  = fire_long;
        rejected_d    = (fire_short | fire_long) & lock;
        mode_d        = mode_q;
        en_d          = en_q;
        busy_d        = (state_d != S_IDLE);

        if (fire_short && !lock) begin
            mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
        end
        if (fire_long && !lock) begin
            en_d   = ~en_q;
            mode_d = '0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            short_flag_q  <= 1'b0;
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
            rejected_q    <= 1'b0;
            mode_q        <= '0;
            en_q          <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            short_flag_q  <= short_flag_d;
            short_press_q <= short_press_d;
            long_press_q  <= long_press_d;
            rejected_q    <= rejected_d;
            mode_q        <= mode_d;
            en_q          <= en_d;
            busy_q        <= busy_d;
        end
    end

    assign short_press = short_press_q;
    assign long_press  = long_press_q;
    assign rejected    = rejected_q;
    assign mode        = mode_q;
    assign en          = en_q;
    assign busy        = busy_q;

endmodule
